tone_seq_ctrl: RTL and testbench
================================

# tone_seq_ctrl

Melody sequencer that drives the 4-bit `key_pad` select of the tone decoder. It stores up to DEPTH (note, duration) pairs in an internal buffer and plays them back in order. Each note is held on `key_pad` for a programmed number of duration ticks, with optional looping and stop control. It sits between the user-input/control logic and the tone decoder, replacing direct keypad drive during playback.

## Interface
Parameters:
- DEPTH, 16: note slots in the buffer (power of two, ≥2).
- TICK_DIV, 100_000: sys_clk cycles per duration tick (1 ms at 100 MHz); ≥2.
- DUR_W, 8: duration field width in ticks.
- GAP_TICKS, 10: silent ticks between notes (used only with TONE_SEQ_GAP_EN).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  append (wr_note, wr_dur) at the buffer tail.
- wr_note  in  4  tone code 1..12; 0 = rest; 13..15 stored as 0.
- wr_dur  in  DUR_W  duration in ticks; 0 stored as 1.
- wr_full  out  1  buffer holds DEPTH entries.
- clear  in  1  empty the buffer (count←0).
- start  in  1  begin playback from slot 0.
- stop  in  1  abort playback.
- loop  in  1  sampled at start: repeat sequence until stop.
- key_pad  out  4  tone select to the tone decoder; 0 = silence.
- busy  out  1  high in any state other than IDLE.
- note_idx  out  log2(DEPTH)  slot currently fetched/playing.
- done  out  1  one-cycle pulse on natural end of a non-looping sequence.

## Operation
- Buffer: DEPTH entries of {4-bit note, DUR_W-bit dur}, and a count register (0..DEPTH).
- Writes and clear are accepted only in IDLE. While busy they are ignored. A write while wr_full is dropped. If clear and wr_en occur in the same cycle, clear wins and the write is dropped.
- States:
  - IDLE → FETCH on start when count>0. Start with count=0 is ignored (no done).
  - FETCH (1 cycle): reads slot note_idx, loads the duration counter and resets the tick prescaler → PLAY.
  - PLAY: the prescaler counts TICK_DIV cycles per tick, and the duration counter decrements on each tick. When it expires → GAP if the macro is enabled and this is not the last note; otherwise → NEXT decision.
  - GAP: key_pad=0 for GAP_TICKS ticks → NEXT decision.
  - NEXT decision (combinational, taken on the transition):
    - not last: note_idx+1 → FETCH.
    - last with loop latched: note_idx←0 → FETCH.
    - last without loop: → IDLE, done pulse.
- key_pad is registered:
  - loaded with the slot's note on the edge entering PLAY.
  - cleared to 0 on the edge entering IDLE or GAP.
  - during FETCH it holds its previous value (0 for the first note).
- stop: from any non-IDLE state → IDLE on the next edge. key_pad=0, no done pulse, note_idx←0. stop has priority over start in the same cycle.
- start while busy is ignored.
- loop is latched only at start. Later changes have no effect.

## Timing
- Reset values: key_pad=0, busy=0, done=0, wr_full=0, note_idx=0, count=0, state IDLE.
- Asynchronous reset mid-playback returns all of the above immediately.
- start sampled at edge E → FETCH after E; first note on key_pad after edge E+1 (2-cycle latency).
- Non-last note (no gap): key_pad holds it for dur·TICK_DIV+1 cycles (PLAY plus the following FETCH).
- Last note: key_pad holds it for dur·TICK_DIV cycles.
- With gap: key_pad holds a note for dur·TICK_DIV cycles, then 0 for GAP_TICKS·TICK_DIV+1 cycles.
- done is asserted in the first IDLE cycle, coincident with key_pad=0 and busy=0.
- wr_full updates the cycle after the write that fills the buffer.

## Configuration
- TONE_SEQ_GAP_EN defined: the GAP state is compiled in, giving a silent separation between consecutive notes, including across a loop wrap (last→slot 0).
- TONE_SEQ_GAP_EN undefined: there is no GAP state, notes are back-to-back, and the GAP_TICKS parameter is unused.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: after reset → key_pad=0, busy=0, done=0, wr_full=0, note_idx=0.
- Basic playback: write (1,2), (5,1), (12,3); pulse start → key_pad=1 for 9 cycles, 5 for 5 cycles, 12 for 12 cycles, then 0; done high for exactly 1 cycle; busy low.
- Loop and stop: write (3,1), (7,1); start with loop=1 → pattern 3,7,3,7 repeats past 3 passes; stop mid-note → key_pad=0 and busy=0 next cycle, done stays 0.
- Full and clear: DEPTH writes → wr_full=1; an extra write is dropped (playback shows DEPTH notes); clear → wr_full=0; start → ignored, busy stays 0.
- Code and duration normalization: write (14,0) → plays key_pad=0 for 4 cycles; writes during playback ignored; start while busy ignored.
- TONE_SEQ_GAP_EN with GAP_TICKS=2, notes (2,1), (4,1): → key_pad 2 for 4 cycles, 0 for 9 cycles, 4 for 4 cycles, then IDLE with no trailing gap.

Source files
------------

// File: rtl/tone_seq_ctrl.sv
// Melody sequencer: buffers (note, duration) pairs and plays them onto key_pad.
// Optional inter-note silence is compiled in with `define TONE_SEQ_GAP_EN.
module tone_seq_ctrl #(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 100_000,
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 10
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_note,
  input  logic [DUR_W-1:0]           wr_dur,
  output logic                       wr_full,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  output logic [3:0]                 key_pad,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   note_idx,
  output logic                       done
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
`ifdef TONE_SEQ_GAP_EN
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam int         GW      = $clog2(GAP_TICKS + 2);
`endif

  localparam logic [IW:0]   CNT_ONE = 1;
  localparam logic [IW-1:0] IDX_ONE = 1;

  logic [1:0]       state;
  logic [3:0]       note_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];
  logic [IW:0]      count;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] dur_cnt;
  logic             loop_q;
  logic             tick;
  logic             last;
  logic             wr_ok;
`ifdef TONE_SEQ_GAP_EN
  logic [GW-1:0]    gap_cnt;
`else
  logic             unused_gap;
  assign unused_gap = ^GAP_TICKS;
`endif

  assign busy    = (state != S_IDLE);
  assign wr_full = (count == (IW+1)'(DEPTH));
  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign last    = (({1'b0, note_idx} + CNT_ONE) == count);
  // clear beats a same-cycle write; nothing is accepted while playing
  assign wr_ok   = (state == S_IDLE) && wr_en && !clear && !wr_full;

  // Out-of-range tone codes become rests, zero durations become one tick
  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      note_mem[count[IW-1:0]] <= (wr_note > 4'd12) ? 4'd0 : wr_note;
      dur_mem[count[IW-1:0]]  <= (wr_dur == '0) ? DUR_W'(1) : wr_dur;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (state == S_IDLE) begin
      if (clear)      count <= '0;
      else if (wr_ok) count <= count + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      key_pad  <= '0;
      note_idx <= '0;
      done     <= 1'b0;
      presc    <= '0;
      dur_cnt  <= '0;
      loop_q   <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (stop && state != S_IDLE) begin
        state    <= S_IDLE;
        key_pad  <= '0;
        note_idx <= '0;
        presc    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop && count != '0) begin
              state    <= S_FETCH;
              note_idx <= '0;
              loop_q   <= loop;
            end
          end
          S_FETCH: begin
            dur_cnt <= dur_mem[note_idx];
            key_pad <= note_mem[note_idx];
            presc   <= '0;
            state   <= S_PLAY;
          end
          S_PLAY: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (dur_cnt == DUR_W'(1)) begin
`ifdef TONE_SEQ_GAP_EN
                if (!last || loop_q) begin
                  state   <= S_GAP;
                  key_pad <= '0;
                  gap_cnt <= GW'(GAP_TICKS);
                end else begin
                  state    <= S_IDLE;
                  key_pad  <= '0;
                  note_idx <= '0;
                  done     <= 1'b1;
                end
`else
                if (!last) begin
                  note_idx <= note_idx + IDX_ONE;
                  state    <= S_FETCH;
                end else if (loop_q) begin
                  note_idx <= '0;
                  state    <= S_FETCH;
                end else begin
                  state    <= S_IDLE;
                  key_pad  <= '0;
                  note_idx <= '0;
                  done     <= 1'b1;
                end
`endif
              end else begin
                dur_cnt <= dur_cnt - DUR_W'(1);
              end
            end
          end
`ifdef TONE_SEQ_GAP_EN
          S_GAP: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (gap_cnt <= GW'(1)) begin
                // only a latched loop reaches here from the last slot
                note_idx <= last ? '0 : note_idx + IDX_ONE;
                state    <= S_FETCH;
              end else begin
                gap_cnt <= gap_cnt - GW'(1);
              end
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl with TICK_DIV=4, DEPTH=4, GAP_TICKS=2.
module tb_tone_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int TD    = 4;
  localparam int DUR_W = 8;
  localparam int GAPT  = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             wr_en, clear, start, stop, loop;
  logic [3:0]       wr_note;
  logic [DUR_W-1:0] wr_dur;
  logic             wr_full, busy, done;
  logic [3:0]       key_pad;
  logic [1:0]       note_idx;

  int total = 0;
  int bad   = 0;

  tone_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TD), .DUR_W(DUR_W), .GAP_TICKS(GAPT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_note(wr_note),
    .wr_dur(wr_dur), .wr_full(wr_full), .clear(clear), .start(start), .stop(stop),
    .loop(loop), .key_pad(key_pad), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] n, input logic [DUR_W-1:0] d);
    wr_en = 1'b1; wr_note = n; wr_dur = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // start pulse; returns at the first cycle the first note is on key_pad
  task automatic go(input logic lp);
    start = 1'b1; loop = lp;
    step();
    start = 1'b0; loop = 1'b0;
    step();
  endtask

  // measures how long key_pad holds v, returns at the first differing cycle
  task automatic run(input logic [3:0] v, input int len, input string tag);
    int n = 0;
    chk({tag, "_val"}, key_pad, v);
    while (key_pad === v && n < 300) begin
      n++;
      step();
    end
    chk({tag, "_len"}, n, len);
  endtask

  task automatic note(input logic [3:0] v, input int dur, input bit fin, input string tag);
`ifdef TONE_SEQ_GAP_EN
    run(v, dur * TD, tag);
    if (!fin) run(4'd0, GAPT * TD + 1, {tag, "_gap"});
`else
    run(v, fin ? dur * TD : dur * TD + 1, tag);
`endif
  endtask

  initial begin
    int n;
    bit nz;
    sys_rst_n = 1'b0;
    wr_en = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_note = '0; wr_dur = '0;
    #12;
    chk("rst_key", key_pad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_idx", note_idx, 0);
    sys_rst_n = 1'b1;
    step();

    // start with an empty buffer is ignored
    start = 1'b1; step(); start = 1'b0;
    chk("empty_start_busy", busy, 0);
    chk("empty_start_done", done, 0);

    // basic playback
    wr(4'd1, 8'd2); wr(4'd5, 8'd1); wr(4'd12, 8'd3);
    start = 1'b1; step(); start = 1'b0;
    chk("fetch_busy", busy, 1);
    chk("fetch_key", key_pad, 0);
    step();
    note(4'd1, 2, 0, "b1");
    chk("b2_idx", note_idx, 1);
    note(4'd5, 1, 0, "b2");
    note(4'd12, 3, 1, "b3");
    chk("b_done", done, 1);
    chk("b_busy", busy, 0);
    chk("b_key", key_pad, 0);
    step();
    chk("b_done_pulse", done, 0);

    // stop beats start in the same cycle
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("stop_start_busy", busy, 0);

    // loop and stop
    do_clear();
    wr(4'd3, 8'd1); wr(4'd7, 8'd1);
    go(1'b1);
    for (int p = 0; p < 3; p++) begin
      note(4'd3, 1, 0, "l3");
      note(4'd7, 1, 0, "l7");
    end
    chk("l_wrap_key", key_pad, 3);
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("l_stop_key", key_pad, 0);
    chk("l_stop_busy", busy, 0);
    chk("l_stop_done", done, 0);
    chk("l_stop_idx", note_idx, 0);
    step();
    chk("l_stop_done2", done, 0);

    // full and clear
    do_clear();
    wr(4'd1, 8'd1); wr(4'd2, 8'd1); wr(4'd3, 8'd1);
    chk("f_not_full", wr_full, 0);
    wr(4'd4, 8'd1);
    chk("f_full", wr_full, 1);
    wr(4'd9, 8'd1);
    go(1'b0);
    note(4'd1, 1, 0, "f1");
    note(4'd2, 1, 0, "f2");
    note(4'd3, 1, 0, "f3");
    note(4'd4, 1, 1, "f4");
    chk("f_done", done, 1);
    step();
    do_clear();
    chk("f_cleared", wr_full, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("f_start_busy", busy, 0);
    step();
    chk("f_start_busy2", busy, 0);

    // normalization; write and start during playback are ignored
    wr(4'd14, 8'd0);
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; step(); start = 1'b0;
      n = 0; nz = 1'b0;
      while (busy === 1'b1 && n < 100) begin
        if (key_pad !== 4'd0) nz = 1'b1;
        wr_en = (n == 2); wr_note = 4'd5; wr_dur = 8'd3;
        start = (n == 3);
        n++;
        step();
      end
      wr_en = 1'b0; start = 1'b0;
      chk("n_busy_len", n, 1 + TD);
      chk("n_silent", nz, 0);
      chk("n_done", done, 1);
      step();
    end

    // asynchronous reset mid-note
    go(1'b0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_key", key_pad, 0);
    chk("ar_busy", busy, 0);
    chk("ar_idx", note_idx, 0);
    chk("ar_full", wr_full, 0);
    chk("ar_done", done, 0);
    #1 sys_rst_n = 1'b1;
    step();

    // two short notes, gap behaviour depends on build
    wr(4'd2, 8'd1); wr(4'd4, 8'd1);
    go(1'b0);
    note(4'd2, 1, 0, "g2");
    note(4'd4, 1, 1, "g4");
    chk("g_done", done, 1);
    chk("g_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
